fault_campaign_ctrl: RTL

Sequencer for fault-injection campaigns on the single-cycle RISC-V core. Holds a golden and a faulty core instance in reset, releases both together, runs them for a fixed number of cycles, and compares their PC and writeback-result traces every cycle. It then reports per-fault detection over a valid/ready result port and advances to the next fault ID. It sits at the fault-simulator top, between the two processor tops and the result logger.

---
 rtl/fault_sim_pkg.sv | 22 ++
 rtl/fault_campaign_ctrl_trace_compare.sv | 32 +++
 rtl/fault_campaign_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/fault_sim_pkg.sv
// fault_sim_pkg: shared campaign-controller types, default parameters and width helper.
package fault_sim_pkg;

   localparam int DEF_NUM_FAULTS = 64;
   localparam int DEF_RUN_CYCLES = 256;
   localparam int DEF_RST_CYCLES = 2;
   localparam int FCC_FIELD_W    = 16;

   typedef enum logic [1:0] {IDLE, RESET, RUN, REPORT} fcc_state_e;

   typedef struct packed {
      logic [FCC_FIELD_W-1:0] fault_id;
      logic                   detected;
      logic [FCC_FIELD_W-1:0] cycle;
   } fcc_result_t;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fault_campaign_ctrl_trace_compare.sv
// trace_compare: per-cycle golden/faulty trace comparison with sticky detect and first-mismatch cycle.
module trace_compare #(
   parameter int CYC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [CYC_W-1:0] cyc,
   input  logic [31:0]      gold_pc,
   input  logic [31:0]      gold_result,
   input  logic [31:0]      fault_pc,
   input  logic [31:0]      fault_result,
   output logic             mismatch,
   output logic             detected,
   output logic [CYC_W-1:0] first_cycle
);

   assign mismatch = en && ((gold_pc != fault_pc) || (gold_result != fault_result));

   // Only the first mismatch of a run is recorded.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         detected    <= 1'b0;
         first_cycle <= '0;
      end else if (mismatch && !detected) begin
         detected    <= 1'b1;
         first_cycle <= cyc;
      end
   end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: sequences reset/run/compare/report for each fault ID of a campaign.
// Optional FAULT_CAMPAIGN_EARLY_EXIT_EN ends a run right after its first mismatch.
module fault_campaign_ctrl
   import fault_sim_pkg::*;
#(
   parameter int NUM_FAULTS = DEF_NUM_FAULTS,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   localparam int FID_W = idx_w(NUM_FAULTS),
   localparam int CYC_W = idx_w(RUN_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             core_rst_n,
   output logic             fault_en,
   output logic [FID_W-1:0] fault_id,
   input  logic [31:0]      gold_pc,
   input  logic [31:0]      gold_result,
   input  logic [31:0]      fault_pc,
   input  logic [31:0]      fault_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [FID_W-1:0] res_fault_id,
   output logic             res_detected,
   output logic [CYC_W-1:0] res_cycle
);

   localparam int RST_W = idx_w(RST_CYCLES + 1);

   fcc_state_e       state, state_nx;
   logic [FID_W-1:0] fault_id_nx;
   logic [CYC_W-1:0] cyc, first_cycle;
   logic [RST_W-1:0] rst_cnt;
   logic             mismatch, detected, cyc_last, run_exit, last_fault;

   assign cyc_last   = cyc == CYC_W'(RUN_CYCLES - 1);
   assign last_fault = fault_id == FID_W'(NUM_FAULTS - 1);
`ifdef FAULT_CAMPAIGN_EARLY_EXIT_EN
   assign run_exit   = cyc_last || mismatch;
`else
   assign run_exit   = cyc_last;
`endif

   trace_compare #(.CYC_W(CYC_W)) u_cmp (
      .clk          (clk),
      .rst          (rst),
      .clear        (state == RESET),
      .en           (state == RUN),
      .cyc          (cyc),
      .gold_pc      (gold_pc),
      .gold_result  (gold_result),
      .fault_pc     (fault_pc),
      .fault_result (fault_result),
      .mismatch     (mismatch),
      .detected     (detected),
      .first_cycle  (first_cycle)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fault_id <= '0;
         cyc      <= '0;
         rst_cnt  <= '0;
      end else begin
         state    <= state_nx;
         fault_id <= fault_id_nx;
         cyc      <= (state == RUN) ? (cyc_last ? cyc : cyc + 1'b1) : '0;
         rst_cnt  <= (state == RESET) ? rst_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nx    = state;
      fault_id_nx = fault_id;
      done        = 1'b0;
      unique case (state)
         IDLE:   state_nx = start ? RESET : IDLE;
         RESET:  state_nx = (rst_cnt == RST_W'(RST_CYCLES - 1)) ? RUN : RESET;
         RUN:    state_nx = run_exit ? REPORT : RUN;
         REPORT: if (res_ready) begin
            done        = last_fault;
            state_nx    = last_fault ? IDLE : RESET;
            fault_id_nx = last_fault ? '0 : fault_id + 1'b1;
         end
      endcase
   end

   assign busy         = state != IDLE;
   assign core_rst_n   = state == RUN;
   assign fault_en     = (state == RESET) || (state == RUN);
   assign res_valid    = state == REPORT;
   assign res_fault_id = fault_id;
   assign res_detected = res_valid && detected;
   assign res_cycle    = res_valid ? first_cycle : '0;

endmodule
